usb_tx_mspeed: RTL and testbench

Parametrised USB serial transmitter for low-speed (1.5 Mb/s) and full-speed (12 Mb/s) links, selectable per packet. It takes bytes from the protocol engine over a valid/ready handshake and drives the differential D+/D- pair through the tri-state `d_port_t` bus. For each packet it generates SYNC, NRZI encoding, bit stuffing, an optional CRC16 and EOP.

---
 rtl/usb_tx_mspeed_pkg.sv | 46 ++++
 rtl/usb_crc16.sv | 31 +++
 rtl/usb_tx_mspeed.sv | 201 ++++++++++++++++++++
 tb/tb_usb_tx_mspeed.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_mspeed_pkg.sv
// rtl/usb_tx_mspeed_pkg.sv - shared USB line types, PIDs, transmitter states and CRC16 constants
package types;

  typedef struct packed {
    logic dp;
    logic dm;
  } d_port_t;

  typedef enum logic [7:0] {
    PID_OUT   = 8'hE1,
    PID_IN    = 8'h69,
    PID_SOF   = 8'hA5,
    PID_SETUP = 8'h2D,
    PID_DATA0 = 8'hC3,
    PID_DATA1 = 8'h4B,
    PID_ACK   = 8'hD2,
    PID_NAK   = 8'h5A,
    PID_STALL = 8'h1E
  } pid_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    CRC_LO,
    CRC_HI,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  localparam d_port_t J_FS = d_port_t'(2'b10);
  localparam d_port_t K_FS = d_port_t'(2'b01);
  localparam d_port_t J_LS = d_port_t'(2'b01);
  localparam d_port_t K_LS = d_port_t'(2'b10);
  localparam d_port_t SE0  = d_port_t'(2'b00);

  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Low speed swaps the J/K polarity of the differential pair.
  function automatic d_port_t line_of(input logic is_j, input logic low_speed);
    if (low_speed) return is_j ? J_LS : K_LS;
    return is_j ? J_FS : K_FS;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - reflected CRC16 (0xA001) with one-bit serial update
module usb_crc16
  import types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = (crc_q >> 1) ^ ((crc_q[0] ^ bit_in) ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) crc_q <= CRC16_INIT;
    else          crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_mspeed.sv
// rtl/usb_tx_mspeed.sv - LS/FS USB serial transmitter: SYNC, NRZI, bit stuffing, CRC16, EOP
module usb_tx_mspeed
  import types::*;
#(
  parameter int CLK_HZ = 24_000_000,
  parameter int DIV_LS = CLK_HZ / 1_500_000,
  parameter int DIV_FS = CLK_HZ / 12_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ls,
  input  logic       crc_en,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output d_port_t    d_o,
  output logic       d_en
);

  localparam int CW = $clog2(DIV_LS + 1);
  localparam logic [CW-1:0] RELOAD_LS = CW'(DIV_LS - 1);
  localparam logic [CW-1:0] RELOAD_FS = CW'(DIV_FS - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    pid_q, pid_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    ones_q, ones_d;
  logic          lvl_q, lvl_d;
  logic          ls_q, ls_d;
  logic          crc_en_q, crc_en_d;
  logic          first_q, first_d;
  logic          arm_q, arm_d;
  logic          busy_q, busy_d;

  logic          strobe, stuff_due, launch, launch_bit;
  logic          crc_init, crc_upd;
  logic [2:0]    next_idx;
  logic [15:0]   crc;

  usb_crc16 u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (crc_init),
    .en      (crc_upd),
    .bit_in  (launch_bit),
    .crc     (crc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    pid_d      = pid_q;
    bit_idx_d  = bit_idx_q;
    ones_d     = ones_q;
    lvl_d      = lvl_q;
    ls_d       = ls_q;
    crc_en_d   = crc_en_q;
    first_d    = first_q;
    busy_d     = busy_q;
    arm_d      = (state_q == IDLE);
    ready      = 1'b0;
    crc_init   = 1'b0;
    crc_upd    = 1'b0;
    launch     = 1'b0;
    launch_bit = 1'b0;
    strobe     = (cnt_q == '0);
    stuff_due  = (ones_q == 3'd6);
    next_idx   = bit_idx_q + 3'd1;

    if (state_q != IDLE) cnt_d = strobe ? (ls_q ? RELOAD_LS : RELOAD_FS) : cnt_q - 1'b1;

    case (state_q)
      IDLE: begin
        // arm_q holds off acceptance for one clock after reset and after every EOP.
        if (arm_q && valid) begin
          ready     = 1'b1;
          ls_d      = ls;
          crc_en_d  = crc_en;
          pid_d     = data;
          crc_init  = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = ls ? RELOAD_LS : RELOAD_FS;
          shift_d   = 8'h80;
          bit_idx_d = 3'd0;
          state_d   = SYNC;
          launch    = 1'b1;
          launch_bit = 1'b0;
        end
      end
      SYNC, DATA, CRC_LO, CRC_HI: begin
        if (strobe) begin
          if (stuff_due) begin
            launch     = 1'b1;
            launch_bit = 1'b0;
          end else if (bit_idx_q != 3'd7) begin
            bit_idx_d  = next_idx;
            launch     = 1'b1;
            launch_bit = shift_q[next_idx];
            crc_upd    = (state_q == DATA) && !first_q;
          end else begin
            bit_idx_d = 3'd0;
            if (state_q == SYNC) begin
              state_d    = DATA;
              shift_d    = pid_q;
              first_d    = 1'b1;
              launch     = 1'b1;
              launch_bit = pid_q[0];
            end else if (state_q == DATA && valid) begin
              ready      = 1'b1;
              shift_d    = data;
              first_d    = 1'b0;
              launch     = 1'b1;
              launch_bit = data[0];
              crc_upd    = 1'b1;
            end else if (state_q == DATA && crc_en_q) begin
              state_d    = CRC_LO;
              shift_d    = ~crc[7:0];
              launch     = 1'b1;
              launch_bit = ~crc[0];
            end else if (state_q == CRC_LO) begin
              state_d    = CRC_HI;
              shift_d    = ~crc[15:8];
              launch     = 1'b1;
              launch_bit = ~crc[8];
            end else begin
              state_d = EOP_SE0;
              ones_d  = 3'd0;
            end
          end
        end
      end
      EOP_SE0: begin
        if (strobe) begin
          if (bit_idx_q == 3'd0) begin
            bit_idx_d = 3'd1;
          end else begin
            state_d = EOP_J;
            lvl_d   = 1'b1;
          end
        end
      end
      EOP_J: begin
        if (strobe) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          lvl_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // NRZI: a 0 toggles the line; only PID..CRC bits feed the stuffing run counter.
    if (launch) begin
      lvl_d  = launch_bit ? lvl_q : ~lvl_q;
      ones_d = (launch_bit && (state_d inside {DATA, CRC_LO, CRC_HI})) ? ones_q + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= 8'h00;
      pid_q     <= 8'h00;
      bit_idx_q <= 3'd0;
      ones_q    <= 3'd0;
      lvl_q     <= 1'b1;
      ls_q      <= 1'b0;
      crc_en_q  <= 1'b0;
      first_q   <= 1'b0;
      arm_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      pid_q     <= pid_d;
      bit_idx_q <= bit_idx_d;
      ones_q    <= ones_d;
      lvl_q     <= lvl_d;
      ls_q      <= ls_d;
      crc_en_q  <= crc_en_d;
      first_q   <= first_d;
      arm_q     <= arm_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    if (!busy_q || state_q == EOP_SE0) d_o = SE0;
    else                               d_o = line_of(lvl_q, ls_q);
  end

  assign busy = busy_q;
  assign d_en = busy_q;

endmodule

// File: tb/tb_usb_tx_mspeed.sv
// tb/tb_usb_tx_mspeed.sv - directed bench: line capture, NRZI/unstuff decode, CRC residual
module tb_usb_tx_mspeed;
  import types::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ls = 1'b0;
  logic       crc_en = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, busy, d_en;
  d_port_t    d_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  rec[$];
  logic [7:0]  dec[$];
  logic [7:0]  pkt[0:7];
  int          n_ready, busy_bad, n_stuff, bad_glitch, bad_stuff;
  logic        sync_ok, eop_ok;
  logic [31:0] sym_vec;
  logic [15:0] res;

  usb_tx_mspeed dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ls      (ls),
    .crc_en  (crc_en),
    .data    (data),
    .valid   (valid),
    .ready   (ready),
    .busy    (busy),
    .d_o     (d_o),
    .d_en    (d_en)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  task automatic run_pkt(input logic l, input logic c, input int n, input bit tog);
    int idx;
    bit started, adv, done;
    rec.delete();
    n_ready = 0; busy_bad = 0; idx = 0; started = 0; adv = 0; done = 0;
    @(posedge clk); #1;
    ls = l; crc_en = c; data = pkt[0]; valid = 1'b1;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      if (busy !== d_en) busy_bad++;
      if (d_en) begin
        rec.push_back(d_o);
        started = 1;
      end else if (started) begin
        done = 1;
      end
      if (ready) begin
        n_ready++;
        adv = 1;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (adv) begin
          adv = 0;
          idx++;
          if (idx < n) data = pkt[idx];
          else valid = 1'b0;
          if (tog && idx == 2) ls = ~ls;
        end
      end
    end
    valid = 1'b0;
    check_eq("packet_end", {31'd0, done}, 32'd1);
  endtask

  task automatic decode(input int div, input logic l);
    logic [1:0] jj, kk, s, prev;
    logic       bitv;
    logic [7:0] cur;
    int nb, ones, nbit, se0_cnt, j_cnt;
    jj = l ? 2'b01 : 2'b10;
    kk = l ? 2'b10 : 2'b01;
    dec.delete();
    n_stuff = 0; bad_glitch = 0; bad_stuff = 0; sync_ok = 1; eop_ok = 1; sym_vec = 0;
    ones = 0; nbit = 0; cur = 0; prev = jj; se0_cnt = 0; j_cnt = 0;
    if (rec.size() % div != 0) bad_glitch++;
    nb = rec.size() / div;
    for (int b = 0; b < nb; b++) begin
      s = rec[b*div];
      for (int k = 1; k < div; k++) if (rec[b*div+k] !== s) bad_glitch++;
      if (b < 16) sym_vec = {sym_vec[29:0], s};
      if (b < 8) begin
        if (s !== ((b == 7 || b % 2 == 0) ? kk : jj)) sync_ok = 0;
        prev = s;
      end else if (s === 2'b00) begin
        se0_cnt++;
      end else if (se0_cnt > 0) begin
        if (s === jj) j_cnt++;
        else eop_ok = 0;
      end else begin
        bitv = (s === prev);
        prev = s;
        if (ones == 6) begin
          if (bitv) bad_stuff++;
          n_stuff++;
          ones = 0;
        end else begin
          ones = bitv ? ones + 1 : 0;
          cur = {bitv, cur[7:1]};
          nbit++;
          if (nbit % 8 == 0) dec.push_back(cur);
        end
      end
    end
    if (se0_cnt != 2 || j_cnt != 1 || nbit % 8 != 0) eop_ok = 0;
  endtask

  task automatic check_ls_ack(input string tag);
    pkt[0] = 8'hD2;
    run_pkt(1'b1, 1'b0, 1, 0);
    decode(16, 1'b1);
    check_eq({tag, "_den_clocks"}, rec.size(), 304);
    check_eq({tag, "_first_k"}, {30'd0, rec[0]}, 32'h2);
    check_eq({tag, "_symbols"}, sym_vec, 32'h999A596A);
    check_eq({tag, "_sync"}, {31'd0, sync_ok}, 32'd1);
    check_eq({tag, "_eop"}, {31'd0, eop_ok}, 32'd1);
    check_eq({tag, "_nbytes"}, dec.size(), 1);
    check_eq({tag, "_pid"}, {24'd0, dec[0]}, 32'hD2);
    check_eq({tag, "_glitch"}, bad_glitch, 0);
    check_eq({tag, "_ready"}, n_ready, 1);
    check_eq({tag, "_busy_den"}, busy_bad, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 valid = 1'b1;
    @(negedge clk);
    check_eq("rst_den", {31'd0, d_en}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_do", {30'd0, d_o}, 32'd0);
    valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    check_ls_ack("ls_ack");

    pkt[0] = 8'hD2;
    run_pkt(1'b0, 1'b0, 1, 0);
    decode(2, 1'b0);
    check_eq("fs_ack_den_clocks", rec.size(), 38);
    check_eq("fs_ack_first_k", {30'd0, rec[0]}, 32'h1);
    check_eq("fs_ack_pid", {24'd0, dec[0]}, 32'hD2);
    check_eq("fs_ack_sync", {31'd0, sync_ok}, 32'd1);
    check_eq("fs_ack_ready", n_ready, 1);

    pkt[0] = 8'hC3;
    run_pkt(1'b0, 1'b1, 1, 0);
    decode(2, 1'b0);
    check_eq("zlp_den_clocks", rec.size(), 70);
    check_eq("zlp_nbytes", dec.size(), 3);
    check_eq("zlp_bytes", {8'd0, dec[0], dec[1], dec[2]}, 32'h00C30000);
    check_eq("zlp_stuff", n_stuff, 0);
    check_eq("zlp_ready", n_ready, 1);
    check_eq("zlp_eop", {31'd0, eop_ok}, 32'd1);

    pkt[0] = 8'h4B; pkt[1] = 8'hFF; pkt[2] = 8'hFF;
    run_pkt(1'b0, 1'b0, 3, 0);
    decode(2, 1'b0);
    check_eq("ff_bytes", {8'd0, dec[0], dec[1], dec[2]}, 32'h004BFFFF);
    check_eq("ff_stuff", n_stuff, 2);
    check_eq("ff_stuff_zero", bad_stuff, 0);
    check_eq("ff_den_clocks", rec.size(), 74);
    check_eq("ff_ready", n_ready, 3);
    check_eq("ff_eop", {31'd0, eop_ok}, 32'd1);

    pkt[0] = 8'hC3; pkt[1] = 8'h01; pkt[2] = 8'hA5; pkt[3] = 8'h7E; pkt[4] = 8'hFC;
    run_pkt(1'b1, 1'b1, 5, 1);
    decode(16, 1'b1);
    check_eq("ls_data_nbytes", dec.size(), 7);
    check_eq("ls_data_payload", {dec[1], dec[2], dec[3], dec[4]}, 32'h01A57EFC);
    res = 16'hFFFF;
    for (int i = 1; i < 7; i++) res = crc_byte(res, dec[i]);
    check_eq("ls_data_residual", {16'd0, res}, 32'h0000B001);
    check_eq("ls_data_den_clocks", rec.size(), (67 + n_stuff) * 16);
    check_eq("ls_data_stuff_zero", bad_stuff, 0);
    check_eq("ls_data_glitch", bad_glitch, 0);
    check_eq("ls_data_ready", n_ready, 5);
    check_eq("ls_data_eop", {31'd0, eop_ok}, 32'd1);

    @(posedge clk); #1;
    ls = 1'b1; crc_en = 1'b0; data = 8'hC3; valid = 1'b1;
    repeat (300) @(posedge clk);
    check_eq("pre_rst_den", {31'd0, d_en}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check_eq("async_rst_den", {31'd0, d_en}, 32'd0);
    check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("async_rst_ready", {31'd0, ready}, 32'd0);
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    check_ls_ack("post_rst_ack");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
